// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: serialises two 12-bit controller words MSB first on
// pmod_clk/pmod_data, then pulses pmod_latch and idles for GAP cycles before the next frame.
module gamepad_pmod_tx #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] buttons1,
  input  logic [11:0] buttons2,
  input  logic        present1,
  input  logic        present2,
  output logic        pmod_clk,
  output logic        pmod_latch,
  output logic        pmod_data,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  // Handshake: none. enable is a level; a frame starts on any IDLE cycle with
  // enable=1, and the inputs are sampled only on that starting edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV - 1 : GAP - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       bit_idx, bit_n;
  logic             half, half_n;
  logic [23:0]      shreg, shreg_n;
  logic [11:0]      w1, w2;

  // An absent controller reads as all ones, matching an open line.
  assign w1 = present1 ? buttons1 : 12'hFFF;
  assign w2 = present2 ? buttons2 : 12'hFFF;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    half_n  = half;
    shreg_n = shreg;
    case (state)
      S_IDLE: begin
        if (enable) begin
          shreg_n = {w1, w2};
          bit_n   = 5'd23;
          cnt_n   = '0;
          half_n  = 1'b0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // half=0 is the low (setup) phase, half=1 the high (hold) phase of a bit.
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (!half) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (bit_idx == 5'd0) state_n = S_LATCH;
            else                 bit_n   = bit_idx - 5'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_LATCH: begin
        if (cnt == DIV_LAST) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      half       <= 1'b0;
      shreg      <= '0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      pmod_data  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      half       <= half_n;
      shreg      <= shreg_n;
      pmod_clk   <= (state_n == S_SHIFT) && half_n;
      pmod_data  <= (state_n == S_SHIFT) && shreg_n[bit_n];
      pmod_latch <= (state_n == S_LATCH);
      busy       <= (state_n != S_IDLE);
      frame_done <= (state_n == S_GAP) && (cnt_n == GAP_LAST);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: a line monitor rebuilds each frame from pmod_clk rising
// edges and compares it with words predicted from the button/present inputs.
module tb_gamepad_pmod_tx;
  localparam int CLK_DIV   = 4;
  localparam int GAP       = 16;
  localparam int FRAME_LEN = 48 * CLK_DIV + CLK_DIV + GAP;
  localparam int LIMIT     = 4 * FRAME_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] buttons1 = '0;
  logic [11:0] buttons2 = '0;
  logic        present1 = 1'b1;
  logic        present2 = 1'b1;
  logic        pmod_clk, pmod_latch, pmod_data, busy, frame_done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  gamepad_pmod_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .buttons1(buttons1), .buttons2(buttons2),
    .present1(present1), .present2(present2),
    .pmod_clk(pmod_clk), .pmod_latch(pmod_latch), .pmod_data(pmod_data),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- line monitor (samples on falling edge) ----------------
  logic        edge_bits[$];
  int          edge_cycs[$];
  int          done_cycs[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  int latch_cnt, latch_start, busy_start, busy_cycles, done_cnt, done_cyc, overlap_cnt, last_edge;
  logic prev_clk = 1'b0, prev_latch = 1'b0, prev_busy = 1'b0;

  function automatic logic [23:0] pack_last();
    logic [23:0] w = '0;
    int n = edge_bits.size();
    for (int i = 0; i < 24; i++)
      if (n - 24 + i >= 0) w[23-i] = edge_bits[n-24+i];
    return w;
  endfunction

  always @(negedge clk) begin
    if (pmod_clk && !prev_clk) begin
      edge_bits.push_back(pmod_data);
      edge_cycs.push_back(cyc);
      last_edge = cyc;
    end
    if (pmod_latch) begin
      latch_cnt++;
      if (!prev_latch) latch_start = cyc;
    end
    if (busy && !prev_busy) busy_start = cyc;
    if (busy) busy_cycles++;
    if (pmod_latch && pmod_clk) overlap_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_cycs.push_back(cyc);
      got_q.push_back(pack_last());
    end
    prev_clk   = pmod_clk;
    prev_latch = pmod_latch;
    prev_busy  = busy;
  end

  // ---------------- reference model and driver tasks ----------------
  function automatic logic [23:0] model_word(logic [11:0] b1, logic [11:0] b2, logic p1, logic p2);
    return {p1 ? b1 : 12'hFFF, p2 ? b2 : 12'hFFF};
  endfunction

  function automatic int bad_spacing();
    int n = 0;
    for (int i = 1; i < edge_cycs.size(); i++)
      if (edge_cycs[i] - edge_cycs[i-1] != 2 * CLK_DIV) n++;
    return n;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    edge_bits.delete(); edge_cycs.delete(); done_cycs.delete(); got_q.delete();
    latch_cnt = 0; latch_start = -1000; busy_start = -1000; busy_cycles = 0;
    done_cnt = 0; done_cyc = -1000; last_edge = -1000;
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < LIMIT && done_cnt < target; n++) wait_cycles(1);
  endtask

  task automatic wait_edges(input int target);
    for (int n = 0; n < LIMIT && edge_cycs.size() < target; n++) wait_cycles(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    wait_cycles(5);
    checks++;
    if ({pmod_clk, pmod_latch, pmod_data, busy, frame_done} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 00000", {pmod_clk, pmod_latch, pmod_data, busy, frame_done});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    reset = 1'b0;
    clear_mon();
    wait_cycles(100);
    checks++;
    if (edge_cycs.size() != 0) begin
      failures++; $display("FAIL idle_edges: got %0d want 0", edge_cycs.size());
    end
    checks++;
    if (busy_cycles != 0) begin
      failures++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_cycles);
    end
  endtask

  task automatic test_single_b();
    logic [23:0] got;
    buttons1 = 12'h800; buttons2 = 12'h000; present1 = 1'b1; present2 = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_cycles(1);
    enable = 1'b0;
    wait_done(1);
    checks++;
    if (done_cnt < 1) begin
      failures++; $display("FAIL single_timeout: frame_done count %0d want 1", done_cnt);
    end
    got = (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx;
    checks++;
    if (edge_cycs.size() != 24) begin
      failures++; $display("FAIL single_edges: got %0d want 24", edge_cycs.size());
    end
    checks++;
    if (got !== model_word(12'h800, 12'h000, 1'b1, 1'b1)) begin
      failures++; $display("FAIL single_word: got %h want %h", got, model_word(12'h800, 12'h000, 1'b1, 1'b1));
    end
    checks++;
    if (got[23] !== 1'b1) begin
      failures++; $display("FAIL single_b_pressed: got %b want 1", got[23]);
    end
    checks++;
    if (edge_cycs.size() == 0 || edge_cycs[0] - busy_start != CLK_DIV) begin
      failures++; $display("FAIL single_first_edge: got offset %0d want %0d",
                           edge_cycs.size() ? edge_cycs[0] - busy_start : -1, CLK_DIV);
    end
    checks++;
    if (bad_spacing() != 0) begin
      failures++; $display("FAIL single_spacing: got %0d bad gaps want 0", bad_spacing());
    end
    checks++;
    if (latch_cnt != CLK_DIV) begin
      failures++; $display("FAIL single_latch_len: got %0d want %0d", latch_cnt, CLK_DIV);
    end
    checks++;
    if (latch_start - last_edge != CLK_DIV) begin
      failures++; $display("FAIL single_latch_pos: got %0d want %0d", latch_start - last_edge, CLK_DIV);
    end
    checks++;
    if (done_cyc - busy_start != FRAME_LEN - 1) begin
      failures++; $display("FAIL single_frame_len: got %0d want %0d", done_cyc - busy_start + 1, FRAME_LEN);
    end
    wait_cycles(5);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      failures++; $display("FAIL single_after: got busy=%b done=%0d want busy=0 done=1", busy, done_cnt);
    end
  endtask

  task automatic test_present2_off();
    logic [23:0] got;
    logic [11:0] b1;
    b1 = 12'($urandom_range(0, 4095));
    buttons1 = b1; buttons2 = 12'h0F0; present1 = 1'b1; present2 = 1'b0;
    clear_mon();
    enable = 1'b1;
    wait_cycles(1);
    enable = 1'b0;
    wait_done(1);
    got = (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx;
    checks++;
    if (got[11:0] !== 12'hFFF) begin
      failures++; $display("FAIL absent_ctrl2: got %h want fff", got[11:0]);
    end
    checks++;
    if (got !== model_word(b1, 12'h0F0, 1'b1, 1'b0)) begin
      failures++; $display("FAIL absent_word: got %h want %h", got, model_word(b1, 12'h0F0, 1'b1, 1'b0));
    end
    present2 = 1'b1;
  endtask

  task automatic test_snapshot();
    buttons1 = 12'h000; buttons2 = 12'h5A5; present1 = 1'b1; present2 = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_edges(19);
    buttons1 = 12'hFFF;
    wait_done(1);
    wait_cycles(2);
    enable = 1'b0;
    wait_done(2);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL snap_frames: got %0d frames want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== model_word(12'h000, 12'h5A5, 1'b1, 1'b1)) begin
        failures++; $display("FAIL snap_first: got %h want %h", got_q[0], model_word(12'h000, 12'h5A5, 1'b1, 1'b1));
      end
      checks++;
      if (got_q[1] !== model_word(12'hFFF, 12'h5A5, 1'b1, 1'b1)) begin
        failures++; $display("FAIL snap_second: got %h want %h", got_q[1], model_word(12'hFFF, 12'h5A5, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_enable_drop();
    buttons1 = 12'h3C3; buttons2 = 12'h00F;
    clear_mon();
    enable = 1'b1;
    wait_edges(14);
    enable = 1'b0;
    wait_done(1);
    checks++;
    if (edge_cycs.size() != 24 || latch_cnt != CLK_DIV || done_cnt != 1) begin
      failures++; $display("FAIL drop_complete: got edges=%0d latch=%0d done=%0d want 24/%0d/1",
                           edge_cycs.size(), latch_cnt, done_cnt, CLK_DIV);
    end
    wait_cycles(300);
    checks++;
    if (edge_cycs.size() != 24 || done_cnt != 1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL drop_idle: got edges=%0d done=%0d busy=%b state=%0d want 24/1/0/0",
                           edge_cycs.size(), done_cnt, busy, dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    buttons1 = 12'hA5A; buttons2 = 12'h123; present1 = 1'b1; present2 = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_edges(12);
    reset = 1'b1;
    wait_cycles(1);
    checks++;
    if ({pmod_clk, pmod_latch, pmod_data, busy, frame_done} !== 5'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL midreset_outputs: got %b state=%0d want 00000 state=0",
                           {pmod_clk, pmod_latch, pmod_data, busy, frame_done}, dbg_state);
    end
    clear_mon();
    reset = 1'b0;
    wait_cycles(1);
    enable = 1'b0;
    wait_done(1);
    got = (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx;
    checks++;
    if (got !== model_word(12'hA5A, 12'h123, 1'b1, 1'b1) || edge_cycs.size() != 24) begin
      failures++; $display("FAIL midreset_frame: got %h edges=%0d want %h edges=24",
                           got, edge_cycs.size(), model_word(12'hA5A, 12'h123, 1'b1, 1'b1));
    end
    checks++;
    if (done_cyc - busy_start != FRAME_LEN - 1) begin
      failures++; $display("FAIL midreset_len: got %0d want %0d", done_cyc - busy_start + 1, FRAME_LEN);
    end
  endtask

  task automatic test_back_to_back();
    localparam int NF = 6;
    logic [23:0] exp_w;
    clear_mon();
    exp_q.delete();
    buttons1 = 12'($urandom); buttons2 = 12'($urandom);
    present1 = 1'($urandom); present2 = 1'($urandom);
    exp_q.push_back(model_word(buttons1, buttons2, present1, present2));
    enable = 1'b1;
    for (int f = 0; f < NF; f++) begin
      wait_done(f + 1);
      if (f < NF - 1) begin
        buttons1 = 12'($urandom); buttons2 = 12'($urandom);
        present1 = 1'($urandom_range(0, 1)); present2 = 1'($urandom_range(0, 1));
        exp_q.push_back(model_word(buttons1, buttons2, present1, present2));
      end else begin
        enable = 1'b0;
      end
    end
    checks++;
    if (got_q.size() != NF) begin
      failures++; $display("FAIL b2b_frames: got %0d want %0d", got_q.size(), NF);
    end
    for (int i = 0; i < NF && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q[0] !== exp_w) begin
        failures++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[0], exp_w);
      end
      void'(got_q.pop_front());
    end
    for (int i = 1; i < done_cycs.size(); i++) begin
      checks++;
      if (done_cycs[i] - done_cycs[i-1] != FRAME_LEN + 1) begin
        failures++; $display("FAIL b2b_period%0d: got %0d want %0d", i, done_cycs[i] - done_cycs[i-1], FRAME_LEN + 1);
      end
    end
    present1 = 1'b1; present2 = 1'b1;
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt != 0) begin
      failures++; $display("FAIL latch_clk_overlap: got %0d cycles want 0", overlap_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    overlap_cnt = 0;
    clear_mon();
    test_reset();
    test_single_b();
    test_present2_off();
    test_snapshot();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    wait_cycles(10);
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
